// File: rtl/digit_serial_adder.sv
// Digit-serial N-bit adder/subtractor: K bits per clock through a K-bit ripple slice with a registered carry.
// Optional signed-overflow output Ovf is enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  output logic         Ovf,
`endif
  output logic [1:0]   dbg_state
);

  localparam int D  = N / K;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic          r_cout;
  logic          r_rdy;
  logic          w_accept;
  logic          w_last;
  logic [K:0]    w_dsum;
  logic          w_cin_msb;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is registered so it stays low through reset and rises one edge after release;
  // out_valid is high only in DONE, and Sum/Cout are frozen until out_ready completes the transfer.
  assign w_accept  = in_valid & r_rdy;
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  assign w_dsum    = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]} + {{K{1'b0}}, r_carry};
  assign w_cin_msb = r_a[K-1] ^ r_b[K-1] ^ w_dsum[K-1];

  assign in_ready  = r_rdy;
  assign out_valid = (r_state == DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == IDLE);
    end
  end

  // Subtraction is A + ~B + 1: B is inverted at load and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum[r_cnt*K +: K] <= w_dsum[K-1:0];
          r_carry             <= w_dsum[K];
          r_a                 <= r_a >> K;
          r_b                 <= r_b >> K;
          r_cnt               <= r_cnt + 1'b1;
          if (w_last) r_cout <= w_dsum[K];
        end
        default: ;
      endcase
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign Ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_cin_msb ^ w_dsum[K];
  end
`else
  logic w_unused;
  assign w_unused = w_cin_msb;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder: N=32/K=8 main instance plus an N=8/K=8 instance.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout;
  logic [31:0] A, B, Sum;
  logic [1:0]  dbg_state;
  logic        d_in_valid, d_in_ready, d_Cin, d_Sub, d_out_valid, d_out_ready, d_Cout;
  logic [7:0]  d_A, d_B, d_Sum;
  logic [1:0]  d_dbg_state;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic        Ovf, d_Ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];  // {ovf, cout, sum}

  always #5 clk = ~clk;

  digit_serial_adder #(.N(32), .K(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    .Ovf(Ovf),
`endif
    .dbg_state(dbg_state)
  );

  digit_serial_adder #(.N(8), .K(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_A), .B(d_B), .Cin(d_Cin), .Sub(d_Sub), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .Sum(d_Sum), .Cout(d_Cout),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    .Ovf(d_Ovf),
`endif
    .dbg_state(d_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_wait", in_ready, 1'b1);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom_range(1)); Sub = 1'($urandom_range(1));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] esum,
                        input logic ecout, input logic eovf, input int hold, input logic rdy_early);
    int lat;
    logic [33:0] e;
    exp_q.push_back({eovf, ecout, esum});
    out_ready = rdy_early;
    send(a, b, cin, sub);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check({tag, "_lat"}, lat, 4);
    e = exp_q.pop_front();
    check({tag, "_sum"}, Sum, e[31:0]);
    check({tag, "_cout"}, Cout, e[32]);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, Ovf, e[33]);
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_sum"}, Sum, e[31:0]);
      check({tag, "_hold_cout"}, Cout, e[32]);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_inrdy"}, in_ready, 1'b0);
      check({tag, "_hold_state"}, dbg_state, 2'd2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_inrdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b0;
    d_in_valid = 1'b0; d_A = '0; d_B = '0; d_Cin = 1'b0; d_Sub = 1'b0; d_out_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sum", Sum, 32'h0);
      check("rst_cout", Cout, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_inrdy", in_ready, 1'b0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_inrdy_pre", in_ready, 1'b0);
    tick();
    check("rel_inrdy", in_ready, 1'b1);

    run_op("fullprop", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub5m7",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b1);
    run_op("bp",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 5, 1'b0);
    run_op("sub7m5",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
    run_op("subovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
    run_op("allones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b1);
    run_op("digcarry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 0, 1'b0);

    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_sum", Sum, 32'h0);
    check("abort_inrdy", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, 1'b0);

    begin
      int lat;
      check("d_inrdy", d_in_ready, 1'b1);
      d_A = 8'hC8; d_B = 8'h64; d_Cin = 1'b0; d_Sub = 1'b0; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0; d_A = 8'hFF; d_B = 8'hFF;
      lat = 0;
      while (!d_out_valid && lat < 10) begin tick(); lat++; end
      check("d_lat", lat, 1);
      check("d_sum", d_Sum, 8'h2C);
      check("d_cout", d_Cout, 1'b1);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      check("d_ovf", d_Ovf, 1'b0);
`endif
      d_out_ready = 1'b1;
      tick();
      d_out_ready = 1'b0;
      check("d_valid_drop", d_out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
